// File: rtl/pc_unit.sv
// Program-counter unit: next-PC selection, RUN/EXC exception state
// machine and a small circular return-address stack.
//
//   state | meaning
//   RUN   | normal instruction flow; exc enters EXC
//   EXC   | inside handler; exc ignored, eret returns to epc
module pc_unit #(
    parameter int          WIDTH        = 32,
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter logic [31:0] EXC_VECTOR   = 32'h0000_0080,
    parameter int          RAS_DEPTH    = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall,
    input  logic             pcsrc,
    input  logic             jump,
    input  logic             jr,
    input  logic             link,
    input  logic             ret,
    input  logic             exc,
    input  logic             eret,
    input  logic [25:0]      instr,
    input  logic [WIDTH-1:0] rs_val,
    output logic [WIDTH-1:0] pc,
    output logic [WIDTH-1:0] pcplus4,
    output logic [WIDTH-1:0] epc,
    output logic             in_exc,
    output logic             ras_empty,
    output logic             ras_full
);

    localparam int PW = $clog2(RAS_DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic {RUN, EXC} state_t;

    state_t           state, state_n;
    logic [WIDTH-1:0] pc_n, epc_n, br_tgt, j_tgt, ras_top;
    logic [WIDTH-1:0] ras_mem [RAS_DEPTH];
    logic [PW-1:0]    wp;
    logic [CW-1:0]    cnt;
    logic             push, pop;

    assign pcplus4   = pc + WIDTH'(4);
    assign br_tgt    = pcplus4 + {{(WIDTH-18){instr[15]}}, instr[15:0], 2'b00};
    assign j_tgt     = {pcplus4[WIDTH-1:28], instr, 2'b00};
    // wp points at the next free slot, so the top is one below it
    assign ras_top   = ras_mem[wp - PW'(1)];
    assign in_exc    = (state == EXC);
    assign ras_empty = (cnt == '0);
    assign ras_full  = (cnt == CW'(RAS_DEPTH));

    // Architectural state register: pc, epc and FSM state
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= RUN;
            pc    <= WIDTH'(RESET_VECTOR);
            epc   <= '0;
        end else begin
            state <= state_n;
            pc    <= pc_n;
            epc   <= epc_n;
        end
    end

    // Next-PC selection in priority order; exception entry beats stall
    always_comb begin
        state_n = state;
        pc_n    = pc;
        epc_n   = epc;
        push    = 1'b0;
        pop     = 1'b0;
        if (state == RUN && exc) begin
            state_n = EXC;
            epc_n   = pc;
            pc_n    = WIDTH'(EXC_VECTOR);
        end else if (stall) begin
            pc_n = pc;
        end else if (state == EXC && eret) begin
            state_n = RUN;
            pc_n    = epc;
        end else if (jr) begin
            pc_n = rs_val;
            if (link) begin
                push = 1'b1;
            end else if (ret && !ras_empty) begin
                pop  = 1'b1;
                pc_n = ras_top;
            end
        end else if (jump) begin
            pc_n = j_tgt;
            push = link;
        end else if (pcsrc) begin
            pc_n = br_tgt;
        end else begin
            pc_n = pcplus4;
        end
    end

    // RAS pointer and occupancy; a push when full overwrites the oldest entry
    always_ff @(posedge clk) begin
        if (reset) begin
            wp  <= '0;
            cnt <= '0;
        end else if (push) begin
            wp <= wp + PW'(1);
            if (!ras_full) cnt <= cnt + CW'(1);
        end else if (pop) begin
            wp  <= wp - PW'(1);
            cnt <= cnt - CW'(1);
        end
    end

    // RAS storage; contents are don't-care after reset
    always_ff @(posedge clk) begin
        if (!reset && push) ras_mem[wp] <= pcplus4;
    end

endmodule

// File: doc/pc_unit.md
PC_UNIT -- requirements
Module: pc_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 32, giving PC/address width (legal range 32..64).
REQ-002 SHALL have parameter RESET_VECTOR, default 32'h0000_0000 (zero-extended to WIDTH), giving the PC after reset.
REQ-003 SHALL have parameter EXC_VECTOR, default 32'h0000_0080 (zero-extended), giving the exception handler address.
REQ-004 SHALL have parameter RAS_DEPTH, default 4, giving return-address-stack entries (power of two, >=2).
REQ-005 clk  input  1  sole clock; all state updates on rising edge.
REQ-006 reset  input  1  synchronous, active-high; wins over every other input.
REQ-007 stall  input  1  hold PC and all state (except exception entry, REQ-016).
REQ-008 pcsrc  input  1  conditional branch taken.
REQ-009 jump  input  1  absolute jump (j/jal).
REQ-010 jr  input  1  register jump to rs_val.
REQ-011 link  input  1  push pcplus4 onto RAS with the jump/jr of this cycle.
REQ-012 ret  input  1  with jr: take target from RAS top and pop.
REQ-013 exc  input  1  exception request; eret  input  1  return from exception.
REQ-014 instr  input  26  instruction bits [25:0]; rs_val  input  WIDTH  register jump target.
REQ-015 Outputs: pc  WIDTH  current PC; pcplus4  WIDTH  pc+4; epc  WIDTH  saved exception PC; in_exc  1  state is EXC; ras_empty  1; ras_full  1.

Function
REQ-016 Next-PC priority: reset > exc (taken in RUN even when stall=1) > stall (hold) > eret > jr > jump > pcsrc > sequential.
REQ-017 pcplus4 = pc + 4, modulo 2^WIDTH; PC wraps from all-ones-minus-3 to 0 with no flag.
REQ-018 Branch target = pcplus4 + (sign-extended instr[15:0] << 2), modulo 2^WIDTH.
REQ-019 Jump target = {pcplus4[WIDTH-1:28], instr[25:0], 2'b00}.
REQ-020 jr target = RAS top if ret=1, link=0 and RAS non-empty; otherwise rs_val.
REQ-021 State machine RUN/EXC: RUN+exc -> EXC, epc<=pc, pc<=EXC_VECTOR, RAS untouched.
REQ-022 EXC+exc: exc ignored, normal selection applies (no nesting, epc unchanged).
REQ-023 EXC+eret (no stall): pc<=epc, -> RUN; RUN+eret: eret ignored, normal selection applies.
REQ-024 in_exc = 1 exactly while state is EXC; registered, no combinational path from exc.
REQ-025 RAS push of pcplus4 occurs only when the cycle commits jump&link or jr&link (not stalled, not overridden by exc/eret).
REQ-026 Push when full: overwrite oldest entry, count stays RAS_DEPTH, write pointer wraps.
REQ-027 Pop only on committed jr&ret&~link with count>0; pop on empty: no count change, target rs_val.
REQ-028 jr&link&ret: ret ignored, push only; push and pop never occur in the same cycle.
REQ-029 ras_empty = (count==0), ras_full = (count==RAS_DEPTH), both registered state-derived.
REQ-030 All outputs change only after a clock edge; pc is a register, zero combinational input-to-pc path.

Reset
REQ-031 On reset: pc=RESET_VECTOR, epc=0, state RUN, in_exc=0, RAS count 0 (ras_empty=1, ras_full=0), RAS contents don't-care.
REQ-032 Reset asserted mid-exception or mid-stall SHALL produce the REQ-031 state on the next edge regardless of other inputs.

Verification
REQ-033 Reset, then 3 idle cycles -> pc 0x0, 0x4, 0x8, 0xC.
REQ-034 pc=0x100, pcsrc=1, instr[15:0]=0xFFFF -> pc=0x100; same with jump=1, instr=0x0000040 -> pc=0x100 (jump wins).
REQ-035 pc=0x200, jump&link; then at 0x40 jr&ret, rs_val=0xDEAD0000 -> pc=0x204, ras_empty=1 after pop.
REQ-036 RAS_DEPTH=4: 5 jal pushes (pcplus4 A..E) then 5 jr&ret -> targets E,D,C,B then rs_val; ras_full=1 after 4th push.
REQ-037 pc=0x300, stall=1, exc=1 -> pc=0x80, epc=0x300, in_exc=1; exc again -> ignored; eret -> pc=0x300, in_exc=0.
REQ-038 In EXC state assert reset with exc=eret=jump=1 -> pc=0x0, epc=0, in_exc=0, ras_empty=1.
